pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_perf.sv | 25 ++
 rtl/pipe_ctrl.sv | 110 +++++++++++
 tb/tb_pipe_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stage indices, FSM encoding, and a stage-mask helper.
// Pure declarations; no timing behaviour of its own.
package pipe_ctrl_pkg;

    localparam int STG_IFID  = 0;
    localparam int STG_IDEX  = 1;
    localparam int STG_EXMEM = 2;
    localparam int STG_MEMWB = 3;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    function automatic logic [3:0] stg(input int idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Stall and redirect event counters for the pipeline controller (PIPE_CTRL_PERF_EN builds only).
// Latency: counts update on the clock edge after the event; no backpressure, counters wrap.
module pipe_ctrl_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  logic        pc_hold,
    input  logic        redir_valid,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (active && pc_hold)
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (redir_valid)
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-register hold/flush, fetch freeze and PC redirect (PIPE_CTRL_PERF_EN adds counters).
// Latency: outputs are combinational from state and inputs; a branch seen under mem_wait redirects the cycle the wait drops.
// Backpressure: mem_wait_i stalls IF..EX and bubbles MEM/WB; ex_busy_i and ld_use_i stall the front end.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int unsigned BOOT_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_use_i,
    input  logic          ex_busy_i,
    input  logic          mem_wait_i,
    input  logic          br_flush_i,
    input  logic [AW-1:0] br_target_i,
    input  logic          exc_i,
    input  logic [AW-1:0] exc_vec_i,
    output logic [3:0]    hold_o,
    output logic [3:0]    flush_o,
    output logic          pc_hold_o,
    output logic          redir_valid_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [AW-1:0] redir_pc_o,
    output logic [31:0]   stall_cnt_o,
    output logic [31:0]   flush_cnt_o
`else
    output logic [AW-1:0] redir_pc_o
`endif
);

    state_t        state, state_nxt;
    logic [3:0]    boot_cnt;
    logic [AW-1:0] pend_pc, pend_pc_nxt;

    always_comb begin
        hold_o        = '0;
        flush_o       = '0;
        pc_hold_o     = 1'b0;
        redir_valid_o = 1'b0;
        redir_pc_o    = '0;
        state_nxt     = state;
        pend_pc_nxt   = pend_pc;
        if (state == ST_BOOT) begin
            flush_o   = 4'hF;
            pc_hold_o = 1'b1;
            if (boot_cnt == 4'(BOOT_CYC - 1))
                state_nxt = ST_RUN;
        end else if (exc_i) begin
            flush_o       = stg(STG_IFID) | stg(STG_IDEX) | stg(STG_EXMEM);
            redir_valid_o = 1'b1;
            redir_pc_o    = exc_vec_i;
            pend_pc_nxt   = '0;
            state_nxt     = ST_RUN;
        end else if (mem_wait_i) begin
            hold_o    = stg(STG_IFID) | stg(STG_IDEX) | stg(STG_EXMEM);
            flush_o   = stg(STG_MEMWB);
            pc_hold_o = 1'b1;
            if (br_flush_i) begin
                pend_pc_nxt = br_target_i;
                state_nxt   = ST_PEND;
            end
        end else if (state == ST_PEND) begin
            // The pending branch is older than anything now in EX, so it wins outright.
            flush_o       = stg(STG_IFID) | stg(STG_IDEX);
            redir_valid_o = 1'b1;
            redir_pc_o    = pend_pc;
            pend_pc_nxt   = '0;
            state_nxt     = ST_RUN;
        end else if (br_flush_i) begin
            flush_o       = stg(STG_IFID) | stg(STG_IDEX);
            redir_valid_o = 1'b1;
            redir_pc_o    = br_target_i;
        end else if (ex_busy_i) begin
            hold_o    = stg(STG_IFID) | stg(STG_IDEX);
            flush_o   = stg(STG_EXMEM);
            pc_hold_o = 1'b1;
        end else if (ld_use_i) begin
            hold_o    = stg(STG_IFID);
            flush_o   = stg(STG_IDEX);
            pc_hold_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
            pend_pc  <= '0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_pc_nxt;
            if (state == ST_BOOT && state_nxt == ST_BOOT)
                boot_cnt <= boot_cnt + 4'd1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_ctrl_perf u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (state != ST_BOOT),
        .pc_hold     (pc_hold_o),
        .redir_valid (redir_valid_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues hand-computed expectations, a negedge monitor pops and compares.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_use_i = 1'b0, ex_busy_i = 1'b0, mem_wait_i = 1'b0, br_flush_i = 1'b0, exc_i = 1'b0;
    logic [31:0] br_target_i = '0, exc_vec_i = '0;
    logic [3:0]  hold_o, flush_o;
    logic        pc_hold_o, redir_valid_o;
    logic [31:0] redir_pc_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [3:0]  hold;
        logic [3:0]  flush;
        logic        pch;
        logic        rv;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.AW(32), .BOOT_CYC(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_use_i      (ld_use_i),
        .ex_busy_i     (ex_busy_i),
        .mem_wait_i    (mem_wait_i),
        .br_flush_i    (br_flush_i),
        .br_target_i   (br_target_i),
        .exc_i         (exc_i),
        .exc_vec_i     (exc_vec_i),
        .hold_o        (hold_o),
        .flush_o       (flush_o),
        .pc_hold_o     (pc_hold_o),
        .redir_valid_o (redir_valid_o),
`ifdef PIPE_CTRL_PERF_EN
        .redir_pc_o    (redir_pc_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
`else
        .redir_pc_o    (redir_pc_o)
`endif
    );

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%h want=%h", tag, what, act, exp);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare it against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "hold",  {28'd0, hold_o},        {28'd0, e.hold});
                chk(e.tag, "flush", {28'd0, flush_o},       {28'd0, e.flush});
                chk(e.tag, "pch",   {31'd0, pc_hold_o},     {31'd0, e.pch});
                chk(e.tag, "rv",    {31'd0, redir_valid_o}, {31'd0, e.rv});
                chk(e.tag, "rpc",   redir_pc_o,             e.pc);
                chk(e.tag, "excl",  {28'd0, hold_o & flush_o}, 32'd0);
            end
        end
    end

    // Apply one cycle of inputs after the edge and queue the response the spec demands for it.
    task automatic step(input string tag, input logic r, input logic [4:0] hz,
                        input logic [31:0] bt, input logic [31:0] ev,
                        input logic [3:0] h, input logic [3:0] f, input logic ph, input logic rv,
                        input logic [31:0] pc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        {exc_i, mem_wait_i, br_flush_i, ex_busy_i, ld_use_i} = hz;
        br_target_i = bt;
        exc_vec_i = ev;
        e.tag = tag; e.hold = h; e.flush = f; e.pch = ph; e.rv = rv; e.pc = pc;
        q.push_back(e);
    endtask

    // hz bit order: exc, mem_wait, br_flush, ex_busy, ld_use
    task automatic idle(input string tag);
        step(tag, 1'b1, 5'b00000, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic boot(input string tag, input logic r);
        step(tag, r, 5'b00000, 32'h0, 32'h0, 4'h0, 4'hF, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        boot("rst0", 1'b0);
        boot("rst1", 1'b0);
        boot("boot0", 1'b1);
        boot("boot1", 1'b1);
        idle("run0");
        idle("run1");

        step("lduse", 1'b1, 5'b00001, 32'h0, 32'h0, 4'b0001, 4'b0010, 1'b1, 1'b0, 32'h0);
        idle("lduse_after");

        step("mw_br", 1'b1, 5'b01100, 32'h100, 32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        step("mw2",   1'b1, 5'b01000, 32'h0,   32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        step("mw3",   1'b1, 5'b01000, 32'h0,   32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        step("pend_go", 1'b1, 5'b00000, 32'h0, 32'h0, 4'b0000, 4'b0011, 1'b0, 1'b1, 32'h100);
        idle("pend_after");

        step("mw_br2", 1'b1, 5'b01100, 32'h200, 32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        step("exc_pend", 1'b1, 5'b11000, 32'h0, 32'h8, 4'b0000, 4'b0111, 1'b0, 1'b1, 32'h8);
        idle("exc_after");
        idle("exc_after2");

        step("mw_br3", 1'b1, 5'b01100, 32'h300, 32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        step("mw_br4", 1'b1, 5'b01100, 32'h340, 32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        step("pend_ow", 1'b1, 5'b00000, 32'h0, 32'h0, 4'b0000, 4'b0011, 1'b0, 1'b1, 32'h340);

        step("busy_ld", 1'b1, 5'b00011, 32'h0, 32'h0, 4'b0011, 4'b0100, 1'b1, 1'b0, 32'h0);
        step("br_run",  1'b1, 5'b00111, 32'h44, 32'h0, 4'b0000, 4'b0011, 1'b0, 1'b1, 32'h44);
        step("mw_busy", 1'b1, 5'b01010, 32'h0, 32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        step("exc_run", 1'b1, 5'b11111, 32'h55, 32'hC0, 4'b0000, 4'b0111, 1'b0, 1'b1, 32'hC0);
        step("pend_pend_br", 1'b1, 5'b01100, 32'h500, 32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        step("pend_br_nowait", 1'b1, 5'b00100, 32'h600, 32'h0, 4'b0000, 4'b0011, 1'b0, 1'b1, 32'h500);

        step("mw_br5", 1'b1, 5'b01100, 32'h700, 32'h0, 4'b0111, 4'b1000, 1'b1, 1'b0, 32'h0);
        boot("rst_pend", 1'b0);
        boot("reboot0", 1'b1);
        boot("reboot1", 1'b1);
        idle("no_stale");
        idle("no_stale2");

`ifdef PIPE_CTRL_PERF_EN
        boot("prst", 1'b0);
        boot("pboot0", 1'b1);
        boot("pboot1", 1'b1);
        for (int i = 0; i < 5; i++)
            step("p_ld", 1'b1, 5'b00001, 32'h0, 32'h0, 4'b0001, 4'b0010, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++)
            step("p_br", 1'b1, 5'b00100, 32'h80, 32'h0, 4'b0000, 4'b0011, 1'b0, 1'b1, 32'h80);
        idle("p_idle");
        @(negedge clk);
        chk("perf", "stall_cnt", stall_cnt_o, 32'd5);
        chk("perf", "flush_cnt", flush_cnt_o, 32'd2);
`endif

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
